// File: rtl/penal_control.sv
// Penalty shoot-out controller: five regulation kicks per team with early
// termination, then sudden death in A/B pairs until the scores differ or both reach 15.
module penal_control (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       goal,
   input  logic       miss,
   output logic       turn,
   output logic [3:0] score_a,
   output logic [3:0] score_b,
   output logic [2:0] kicks_a,
   output logic [2:0] kicks_b,
   output logic       sudden,
   output logic       done,
   output logic [1:0] winner
);

   typedef enum logic [2:0] {IDLE, KICK_A, KICK_B, SD_A, SD_B, END} state_t;

   state_t     state;
   logic       start_q, goal_q, miss_q;
   logic       start_e, goal_e, miss_e, kick;
   logic [3:0] nsa, nsb;
   logic [2:0] nka, nkb, rem_a, rem_b;
   logic       a_lost, b_lost;

   assign start_e = start & ~start_q;
   assign goal_e  = goal  & ~goal_q;
   assign miss_e  = miss  & ~miss_q;
   assign kick    = goal_e ^ miss_e;

   // Post-kick counts, so the termination decision lands on the same edge.
   always_comb begin
      nsa = score_a;
      nsb = score_b;
      nka = kicks_a;
      nkb = kicks_b;
      if (state == KICK_A || state == SD_A) begin
         if (goal_e && score_a != 4'd15) nsa = score_a + 4'd1;
         if (state == KICK_A)             nka = kicks_a + 3'd1;
      end else if (state == KICK_B || state == SD_B) begin
         if (goal_e && score_b != 4'd15) nsb = score_b + 4'd1;
         if (state == KICK_B)             nkb = kicks_b + 3'd1;
      end
      rem_a  = 3'd5 - nka;
      rem_b  = 3'd5 - nkb;
      a_lost = ({1'b0, nsa} + {2'b00, rem_a}) < {1'b0, nsb};
      b_lost = ({1'b0, nsb} + {2'b00, rem_b}) < {1'b0, nsa};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         // Treated as already high so a level held across reset release needs a low sample first.
         start_q <= 1'b1;
         goal_q  <= 1'b1;
         miss_q  <= 1'b1;
         turn    <= 1'b0;
         score_a <= '0;
         score_b <= '0;
         kicks_a <= '0;
         kicks_b <= '0;
         sudden  <= 1'b0;
         done    <= 1'b0;
         winner  <= '0;
      end else begin
         start_q <= start;
         goal_q  <= goal;
         miss_q  <= miss;
         case (state)
            IDLE, END: begin
               if (start_e) begin
                  state   <= KICK_A;
                  turn    <= 1'b0;
                  score_a <= '0;
                  score_b <= '0;
                  kicks_a <= '0;
                  kicks_b <= '0;
                  sudden  <= 1'b0;
                  done    <= 1'b0;
                  winner  <= '0;
               end
            end
            KICK_A, KICK_B: begin
               if (kick) begin
                  score_a <= nsa;
                  score_b <= nsb;
                  kicks_a <= nka;
                  kicks_b <= nkb;
                  if (a_lost || b_lost) begin
                     state  <= END;
                     turn   <= 1'b0;
                     done   <= 1'b1;
                     winner <= a_lost ? 2'b10 : 2'b01;
                  end else if (state == KICK_B && nka == 3'd5 && nkb == 3'd5) begin
                     // Neither side lost with no kicks left, so the scores are level.
                     state  <= SD_A;
                     turn   <= 1'b0;
                     sudden <= 1'b1;
                  end else begin
                     state <= (state == KICK_A) ? KICK_B : KICK_A;
                     turn  <= (state == KICK_A);
                  end
               end
            end
            SD_A: begin
               if (kick) begin
                  score_a <= nsa;
                  state   <= SD_B;
                  turn    <= 1'b1;
               end
            end
            SD_B: begin
               if (kick) begin
                  score_b <= nsb;
                  turn    <= 1'b0;
                  if (nsa != nsb || nsa == 4'd15) begin
                     state  <= END;
                     sudden <= 1'b0;
                     done   <= 1'b1;
                     winner <= (nsa > nsb) ? 2'b01 : (nsb > nsa) ? 2'b10 : 2'b00;
                  end else begin
                     state <= SD_A;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_penal_control.sv
// Directed bench for penal_control: each task drives one scenario and checks
// the packed output snapshot against hand-computed values.
module tb_penal_control;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, goal = 1'b0, miss = 1'b0;
   logic       turn, sudden, done;
   logic [3:0] score_a, score_b;
   logic [2:0] kicks_a, kicks_b;
   logic [1:0] winner;
   logic [18:0] snap, exp_v;
   int checks = 0;
   int errors = 0;

   penal_control dut (
      .clk(clk), .rst(rst), .start(start), .goal(goal), .miss(miss),
      .turn(turn), .score_a(score_a), .score_b(score_b),
      .kicks_a(kicks_a), .kicks_b(kicks_b),
      .sudden(sudden), .done(done), .winner(winner)
   );

   always #5 clk = ~clk;

   assign snap = {turn, score_a, score_b, kicks_a, kicks_b, sudden, done, winner};

   function automatic logic [18:0] mk(input logic t, input logic [3:0] sa, input logic [3:0] sb,
                                      input logic [2:0] ka, input logic [2:0] kb,
                                      input logic sd, input logic dn, input logic [1:0] w);
      return {t, sa, sb, ka, kb, sd, dn, w};
   endfunction

   task automatic kick(input logic g, input logic m);
      @(negedge clk); goal = g; miss = m;
      @(negedge clk); goal = 1'b0; miss = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic begin_match();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      pulse_start();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      exp_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL reset_state: got %h expected %h", snap, exp_v); end
      checks++;
      @(negedge clk); rst = 1'b1;
      pulse_start();
      exp_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL start_kick_a: got %h expected %h", snap, exp_v); end
      checks++;
   endtask

   task automatic test_early_win();
      kick(1, 0); kick(0, 1); kick(1, 0); kick(0, 1); kick(1, 0);
      exp_v = mk(1, 3, 0, 3, 2, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL early_win_5th: got %h expected %h", snap, exp_v); end
      checks++;
      @(negedge clk); miss = 1'b1;
      @(posedge clk); #1;
      exp_v = mk(0, 3, 0, 3, 3, 0, 1, 2'b01);
      if (snap !== exp_v) begin errors++; $display("FAIL early_win_latency: got %h expected %h", snap, exp_v); end
      checks++;
      @(negedge clk); miss = 1'b0;
   endtask

   task automatic test_restart();
      pulse_start();
      exp_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL restart_clear: got %h expected %h", snap, exp_v); end
      checks++;
      kick(1, 0);
      exp_v = mk(1, 1, 0, 1, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL restart_kick_a: got %h expected %h", snap, exp_v); end
      checks++;
   endtask

   task automatic test_sudden();
      logic [9:0] pat;
      begin_match();
      pat = 10'b1100110000; // per kick, A first: G G M M G G M M M M
      for (int i = 9; i >= 0; i--) kick(pat[i], ~pat[i]);
      exp_v = mk(0, 2, 2, 5, 5, 1, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL sudden_enter: got %h expected %h", snap, exp_v); end
      checks++;
      kick(1, 0);
      exp_v = mk(1, 3, 2, 5, 5, 1, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL sudden_a_goal: got %h expected %h", snap, exp_v); end
      checks++;
      kick(0, 1);
      exp_v = mk(0, 3, 2, 5, 5, 0, 1, 2'b01);
      if (snap !== exp_v) begin errors++; $display("FAIL sudden_end: got %h expected %h", snap, exp_v); end
      checks++;
   endtask

   task automatic test_simultaneous();
      begin_match();
      kick(1, 1);
      exp_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL simultaneous: got %h expected %h", snap, exp_v); end
      checks++;
      @(negedge clk); goal = 1'b1;
      repeat (10) @(negedge clk);
      goal = 1'b0;
      @(negedge clk);
      exp_v = mk(1, 1, 0, 1, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL held_goal: got %h expected %h", snap, exp_v); end
      checks++;
      pulse_start();
      exp_v = mk(1, 1, 0, 1, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL start_ignored: got %h expected %h", snap, exp_v); end
      checks++;
   endtask

   task automatic test_reset_mid();
      begin_match();
      kick(1, 0); kick(0, 1); kick(1, 0); kick(0, 1);
      exp_v = mk(0, 2, 0, 2, 2, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL mid_before_rst: got %h expected %h", snap, exp_v); end
      checks++;
      @(posedge clk); #2;
      rst = 1'b0; start = 1'b1;
      #1;
      exp_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL async_rst: got %h expected %h", snap, exp_v); end
      checks++;
      @(negedge clk); rst = 1'b1;
      repeat (3) @(negedge clk);
      kick(1, 0); kick(1, 0);
      exp_v = mk(0, 0, 0, 0, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL idle_ignore: got %h expected %h", snap, exp_v); end
      checks++;
      start = 1'b0;
      pulse_start();
      kick(1, 0);
      exp_v = mk(1, 1, 0, 1, 0, 0, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL start_after_low: got %h expected %h", snap, exp_v); end
      checks++;
   endtask

   task automatic test_saturation();
      begin_match();
      repeat (5) begin kick(1, 0); kick(1, 0); end
      exp_v = mk(0, 5, 5, 5, 5, 1, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL sat_enter_sd: got %h expected %h", snap, exp_v); end
      checks++;
      repeat (9) begin kick(1, 0); kick(1, 0); end
      exp_v = mk(0, 14, 14, 5, 5, 1, 0, 0);
      if (snap !== exp_v) begin errors++; $display("FAIL sat_14_14: got %h expected %h", snap, exp_v); end
      checks++;
      kick(1, 0); kick(1, 0);
      exp_v = mk(0, 15, 15, 5, 5, 0, 1, 2'b00);
      if (snap !== exp_v) begin errors++; $display("FAIL sat_15_15: got %h expected %h", snap, exp_v); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_early_win();
      test_restart();
      test_sudden();
      test_simultaneous();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
